uart_cmd_wrapper: RTL

DUT-side endpoint of the remote command link. It is the responder for the 16-bit command initiator on the remote side. Integrated UART receiver and transmitter (8N1). Receives two serial bytes (high byte first), assembles them into a 16-bit command and flags it to cmd_proc. Transmits the 8-bit response (e.g. 0xA5 positive ack) back on TX when cmd_proc requests it.

---
 rtl/uart_cmd_wrapper.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: remote command link endpoint.
// 8N1 UART receiver assembles two bytes (high first) into a 16-bit command
// for cmd_proc; 8N1 transmitter sends the response byte back on request.
// RX and TX run fully independently (full duplex).
// Optional inter-byte timeout in WAIT_LO: define UART_CMD_TIMEOUT_EN.
//
// state       | meaning
// RX_IDLE     | waiting for falling edge on synchronized RX
// RX_START    | half-bit wait, start bit qualified at mid-bit
// RX_DATA     | sampling 8 data bits LSB first
// RX_STOP     | sampling stop bit, byte good or framing error
// AS_WAIT_HI  | waiting for high command byte
// AS_WAIT_LO  | high byte held, waiting for low command byte
// TX_IDLE     | line idle high, waiting for trmt
// TX_XMIT     | shifting out start, 8 data, stop
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 5208,
  parameter int TMO_BITS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {AS_WAIT_HI, AS_WAIT_LO} as_state_e;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_e;

  // ---------------- RX path ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic             rx_fall;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_sh_q;
  logic             rx_tc;
  logic             rx_ld_half, rx_start_ok, rx_shift, byte_good, byte_bad;

  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_tc   = (rx_cnt_q == CNT_W'(1));

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_q <= RX_IDLE;
    else        rx_state_q <= rx_state_d;
  end

  // RX next-state logic; a start bit that reads high at mid-bit is a glitch
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_tc) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tc && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_tc) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX control strobes
  always_comb begin
    rx_ld_half  = (rx_state_q == RX_IDLE) && rx_fall;
    rx_start_ok = (rx_state_q == RX_START) && rx_tc && !rx_sync_q;
    rx_shift    = (rx_state_q == RX_DATA) && rx_tc;
    byte_good   = (rx_state_q == RX_STOP) && rx_tc && rx_sync_q;
    byte_bad    = (rx_state_q == RX_STOP) && rx_tc && !rx_sync_q;
  end

  // Baud down-counter, bit counter and LSB-first data shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      if (rx_ld_half)                 rx_cnt_q <= BAUD_HALF;
      else if (rx_start_ok || rx_shift) rx_cnt_q <= BAUD_FULL;
      else if (rx_cnt_q != '0)        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
      if (rx_start_ok)   rx_bit_q <= '0;
      else if (rx_shift) rx_bit_q <= rx_bit_q + 3'd1;
      if (rx_shift) rx_sh_q <= {rx_sync_q, rx_sh_q[7:1]};
    end
  end

  // ---------------- command assembly ----------------
  as_state_e   as_state_q, as_state_d;
  logic [7:0]  hi_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic        ld_hi, ld_cmd, start_clr;
  logic        tmo_expire;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_CLKS = TMO_BITS * BAUD_DIV;
  localparam int TMO_W    = $clog2(TMO_CLKS + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_arm_q;

  // Inter-byte timer: armed by a completed high byte, disarmed by the next start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_arm_q <= 1'b0;
    end else if (ld_hi) begin
      tmo_cnt_q <= TMO_W'(TMO_CLKS);
      tmo_arm_q <= 1'b1;
    end else if (as_state_q != AS_WAIT_LO || rx_ld_half) begin
      tmo_arm_q <= 1'b0;
    end else if (tmo_cnt_q != '0) begin
      tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
    end
  end

  assign tmo_expire = tmo_arm_q && (tmo_cnt_q == '0);
`else
  // No timer: WAIT_LO waits indefinitely (TMO_BITS has no effect)
  assign tmo_expire = (TMO_BITS < 0);
`endif

  // Assembly state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) as_state_q <= AS_WAIT_HI;
    else        as_state_q <= as_state_d;
  end

  // Assembly next-state: a bad byte or timeout in WAIT_LO drops the high byte
  always_comb begin
    as_state_d = as_state_q;
    case (as_state_q)
      AS_WAIT_HI: if (byte_good) as_state_d = AS_WAIT_LO;
      AS_WAIT_LO: if (byte_good || byte_bad || tmo_expire) as_state_d = AS_WAIT_HI;
      default:    as_state_d = AS_WAIT_HI;
    endcase
  end

  // Assembly strobes; a new start bit in WAIT_HI retires the previous command flag
  always_comb begin
    ld_hi     = (as_state_q == AS_WAIT_HI) && byte_good;
    ld_cmd    = (as_state_q == AS_WAIT_LO) && byte_good;
    start_clr = (as_state_q == AS_WAIT_HI) && rx_ld_half;
  end

  // High byte, command and ready flag; setting the flag beats clearing it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      if (ld_hi)  hi_q  <= rx_sh_q;
      if (ld_cmd) cmd_q <= {hi_q, rx_sh_q};
      if (ld_cmd)                        cmd_rdy_q <= 1'b1;
      else if (clr_cmd_rdy || start_clr) cmd_rdy_q <= 1'b0;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  // ---------------- TX path ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bit_q;
  logic [9:0]       tx_sh_q;
  logic             tx_done_q;
  logic             tx_tc, tx_load, tx_shift, tx_finish;

  assign tx_tc = (tx_cnt_q == CNT_W'(1));

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_q <= TX_IDLE;
    else        tx_state_q <= tx_state_d;
  end

  // TX next-state; trmt is only honoured from IDLE
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (trmt) tx_state_d = TX_XMIT;
      TX_XMIT: if (tx_tc && tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX control strobes
  always_comb begin
    tx_load   = (tx_state_q == TX_IDLE) && trmt;
    tx_shift  = (tx_state_q == TX_XMIT) && tx_tc;
    tx_finish = (tx_state_q == TX_XMIT) && tx_tc && (tx_bit_q == 4'd9);
  end

  // Frame shifter fills with ones so the line rests high after the stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_q   <= '1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      if (tx_load) begin
        tx_sh_q  <= {1'b1, resp, 1'b0};
        tx_cnt_q <= BAUD_FULL;
        tx_bit_q <= '0;
      end else if (tx_shift) begin
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        tx_cnt_q <= BAUD_FULL;
        tx_bit_q <= tx_bit_q + 4'd1;
      end else if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
      end
      if (tx_load)        tx_done_q <= 1'b0;
      else if (tx_finish) tx_done_q <= 1'b1;
    end
  end

  assign TX      = tx_sh_q[0];
  assign tx_done = tx_done_q;

endmodule
